// File: rtl/issue_unit.sv
// issue_unit -- single-entry in-order issue stage with a register scoreboard.
//
// Holds at most one decoded instruction. The held entry is sent to one of
// three functional units (ALU, MUL, MEM) once its source and destination
// registers are free and the chosen unit is ready. Writeback results are
// forwarded into the operands in the same cycle they appear.
//
// Ports
//   clock, reset (async, active-low)
//   id_iss_*      decoded instruction in; iss_stall back-pressure to decode
//   iss_reg_addr* register-file read addresses; reg_iss_data* read data
//   wb_iss_*      writeback port (clears pending bits, feeds the bypass)
//   *_iss_ready   FU ready; iss_*_valid one-cycle dispatch strobes
//   iss_ex_*      shared, registered dispatch payload
//   ex_iss_flush  drop the held instruction
//   iss_stall_cycles  saturating count of cycles spent stalled
module issue_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_iss_valid,
    input  logic [6:0]  id_iss_opcode,
    input  logic [2:0]  id_iss_funct3,
    input  logic [6:0]  id_iss_funct7,
    input  logic [2:0]  id_iss_aluop,
    input  logic        id_iss_selimregb,
    input  logic [31:0] id_iss_imedext,
    input  logic [4:0]  id_iss_regdest,
    input  logic        id_iss_writereg,
    input  logic        id_iss_readmem,
    input  logic        id_iss_writemem,
    input  logic [4:0]  id_iss_addra,
    input  logic [4:0]  id_iss_addrb,
    output logic        iss_stall,
    output logic [4:0]  iss_reg_addra,
    output logic [4:0]  iss_reg_addrb,
    input  logic [31:0] reg_iss_dataa,
    input  logic [31:0] reg_iss_datab,
    input  logic        wb_iss_writereg,
    input  logic [4:0]  wb_iss_addr,
    input  logic [31:0] wb_iss_data,
    input  logic        alu_iss_ready,
    input  logic        mul_iss_ready,
    input  logic        mem_iss_ready,
    output logic        iss_alu_valid,
    output logic        iss_mul_valid,
    output logic        iss_mem_valid,
    output logic [31:0] iss_ex_opa,
    output logic [31:0] iss_ex_opb,
    output logic [31:0] iss_ex_imm,
    output logic [2:0]  iss_ex_aluop,
    output logic [2:0]  iss_ex_funct3,
    output logic [4:0]  iss_ex_regdest,
    output logic        iss_ex_writereg,
    output logic        iss_ex_readmem,
    output logic        iss_ex_writemem,
    input  logic        ex_iss_flush,
    output logic [15:0] iss_stall_cycles
);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

    state_t      state_reg, state_next;

    // Held instruction fields
    logic [6:0]  opcode_reg;
    logic [2:0]  funct3_reg;
    logic [6:0]  funct7_reg;
    logic [2:0]  aluop_reg;
    logic        selimregb_reg;
    logic [31:0] imedext_reg;
    logic [4:0]  regdest_reg;
    logic        writereg_reg;
    logic        readmem_reg;
    logic        writemem_reg;
    logic [4:0]  addra_reg;
    logic [4:0]  addrb_reg;

    logic [31:0] pending_reg, pending_next;
    logic [31:0] wb_mask;
    logic [31:0] eff_pending;
    logic        sel_mul, sel_mem, sel_alu;
    logic        fu_ready;
    logic        hazard_a, hazard_b, hazard_waw;
    logic        dispatch, capture;
    logic [31:0] opa_byp, opb_byp;

    // One-hot of the register being written back this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_wb_mask
            assign wb_mask[gi] = wb_iss_writereg && (wb_iss_addr == 5'(gi));
        end
    endgenerate

    // A writeback in this cycle already satisfies the dependency because
    // its data is bypassed into the operands below.
    assign eff_pending = pending_reg & ~wb_mask;

    assign sel_mul = (opcode_reg == 7'b0110011) && (funct7_reg == 7'b0000001);
    assign sel_mem = (opcode_reg == 7'b0000011) || (opcode_reg == 7'b0100011);
    assign sel_alu = !sel_mul && !sel_mem;
    assign fu_ready = sel_mul ? mul_iss_ready :
                      sel_mem ? mem_iss_ready : alu_iss_ready;

    assign hazard_a   = (addra_reg != 5'd0) && eff_pending[addra_reg];
    assign hazard_b   = (addrb_reg != 5'd0) && eff_pending[addrb_reg];
    assign hazard_waw = writereg_reg && eff_pending[regdest_reg];

    assign dispatch = (state_reg == HELD) && !ex_iss_flush && !hazard_a &&
                      !hazard_b && !hazard_waw && fu_ready;
    assign iss_stall = (state_reg == HELD) && !dispatch;
    assign capture   = id_iss_valid && !iss_stall && !ex_iss_flush;

    assign iss_reg_addra = addra_reg;
    assign iss_reg_addrb = addrb_reg;

    assign opa_byp = (addra_reg == 5'd0)  ? 32'd0 :
                     wb_mask[addra_reg]   ? wb_iss_data : reg_iss_dataa;
    assign opb_byp = (addrb_reg == 5'd0)  ? 32'd0 :
                     wb_mask[addrb_reg]   ? wb_iss_data : reg_iss_datab;

    // Holding-register FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= EMPTY;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (ex_iss_flush)  state_next = EMPTY;
        else if (capture)  state_next = HELD;
        else if (dispatch) state_next = EMPTY;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opcode_reg    <= '0;
            funct3_reg    <= '0;
            funct7_reg    <= '0;
            aluop_reg     <= '0;
            selimregb_reg <= 1'b0;
            imedext_reg   <= '0;
            regdest_reg   <= '0;
            writereg_reg  <= 1'b0;
            readmem_reg   <= 1'b0;
            writemem_reg  <= 1'b0;
            addra_reg     <= '0;
            addrb_reg     <= '0;
        end else if (capture) begin
            opcode_reg    <= id_iss_opcode;
            funct3_reg    <= id_iss_funct3;
            funct7_reg    <= id_iss_funct7;
            aluop_reg     <= id_iss_aluop;
            selimregb_reg <= id_iss_selimregb;
            imedext_reg   <= id_iss_imedext;
            regdest_reg   <= id_iss_regdest;
            writereg_reg  <= id_iss_writereg;
            readmem_reg   <= id_iss_readmem;
            writemem_reg  <= id_iss_writemem;
            addra_reg     <= id_iss_addra;
            addrb_reg     <= id_iss_addrb;
        end
    end

    // Scoreboard: writeback clears, dispatch sets; the set is applied last
    // so it wins when both hit the same register. x0 is never pending.
    always_comb begin
        pending_next = pending_reg & ~wb_mask;
        if (dispatch && writereg_reg && (regdest_reg != 5'd0))
            pending_next[regdest_reg] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pending_reg <= '0;
        else        pending_reg <= pending_next;
    end

    // Registered dispatch strobes and payload
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iss_alu_valid   <= 1'b0;
            iss_mul_valid   <= 1'b0;
            iss_mem_valid   <= 1'b0;
            iss_ex_opa      <= '0;
            iss_ex_opb      <= '0;
            iss_ex_imm      <= '0;
            iss_ex_aluop    <= '0;
            iss_ex_funct3   <= '0;
            iss_ex_regdest  <= '0;
            iss_ex_writereg <= 1'b0;
            iss_ex_readmem  <= 1'b0;
            iss_ex_writemem <= 1'b0;
        end else begin
            iss_alu_valid <= dispatch && sel_alu;
            iss_mul_valid <= dispatch && sel_mul;
            iss_mem_valid <= dispatch && sel_mem;
            if (dispatch) begin
                iss_ex_opa      <= opa_byp;
                iss_ex_opb      <= selimregb_reg ? imedext_reg : opb_byp;
                iss_ex_imm      <= imedext_reg;
                iss_ex_aluop    <= aluop_reg;
                iss_ex_funct3   <= funct3_reg;
                iss_ex_regdest  <= regdest_reg;
                iss_ex_writereg <= writereg_reg;
                iss_ex_readmem  <= readmem_reg;
                iss_ex_writemem <= writemem_reg;
            end
        end
    end

    // Stall counter: flushed cycles are not counted as stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            iss_stall_cycles <= '0;
        else if ((state_reg == HELD) && !dispatch && !ex_iss_flush &&
                 (iss_stall_cycles != 16'hFFFF))
            iss_stall_cycles <= iss_stall_cycles + 16'd1;
    end

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model of the issue stage.
module tb_issue_unit;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  aop;
        logic        sel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wr;
        logic        rm;
        logic        wm;
        logic [4:0]  ra;
        logic [4:0]  rb;
    } instr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    instr_t      in_i;
    logic        id_iss_valid, iss_stall;
    logic [4:0]  iss_reg_addra, iss_reg_addrb;
    logic [31:0] reg_iss_dataa, reg_iss_datab;
    logic        wb_iss_writereg;
    logic [4:0]  wb_iss_addr;
    logic [31:0] wb_iss_data;
    logic        alu_iss_ready, mul_iss_ready, mem_iss_ready;
    logic        iss_alu_valid, iss_mul_valid, iss_mem_valid;
    logic [31:0] iss_ex_opa, iss_ex_opb, iss_ex_imm;
    logic [2:0]  iss_ex_aluop, iss_ex_funct3;
    logic [4:0]  iss_ex_regdest;
    logic        iss_ex_writereg, iss_ex_readmem, iss_ex_writemem;
    logic        ex_iss_flush;
    logic [15:0] iss_stall_cycles;

    logic [31:0] rf [32];
    assign reg_iss_dataa = rf[iss_reg_addra];
    assign reg_iss_datab = rf[iss_reg_addrb];

    always #5 clock = ~clock;

    issue_unit dut (
        .clock(clock), .reset(reset),
        .id_iss_valid(id_iss_valid), .id_iss_opcode(in_i.opc),
        .id_iss_funct3(in_i.f3), .id_iss_funct7(in_i.f7),
        .id_iss_aluop(in_i.aop), .id_iss_selimregb(in_i.sel),
        .id_iss_imedext(in_i.imm), .id_iss_regdest(in_i.rd),
        .id_iss_writereg(in_i.wr), .id_iss_readmem(in_i.rm),
        .id_iss_writemem(in_i.wm), .id_iss_addra(in_i.ra),
        .id_iss_addrb(in_i.rb), .iss_stall(iss_stall),
        .iss_reg_addra(iss_reg_addra), .iss_reg_addrb(iss_reg_addrb),
        .reg_iss_dataa(reg_iss_dataa), .reg_iss_datab(reg_iss_datab),
        .wb_iss_writereg(wb_iss_writereg), .wb_iss_addr(wb_iss_addr),
        .wb_iss_data(wb_iss_data),
        .alu_iss_ready(alu_iss_ready), .mul_iss_ready(mul_iss_ready),
        .mem_iss_ready(mem_iss_ready),
        .iss_alu_valid(iss_alu_valid), .iss_mul_valid(iss_mul_valid),
        .iss_mem_valid(iss_mem_valid),
        .iss_ex_opa(iss_ex_opa), .iss_ex_opb(iss_ex_opb),
        .iss_ex_imm(iss_ex_imm), .iss_ex_aluop(iss_ex_aluop),
        .iss_ex_funct3(iss_ex_funct3), .iss_ex_regdest(iss_ex_regdest),
        .iss_ex_writereg(iss_ex_writereg), .iss_ex_readmem(iss_ex_readmem),
        .iss_ex_writemem(iss_ex_writemem),
        .ex_iss_flush(ex_iss_flush), .iss_stall_cycles(iss_stall_cycles)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic         m_held;
    instr_t       m_ins;
    logic [31:0]  m_pend;
    logic [2:0]   m_v;      // {alu, mul, mem}
    logic [127:0] m_pay;
    int           m_cnt;

    function automatic logic [127:0] dut_pay();
        return 128'({iss_ex_opa, iss_ex_opb, iss_ex_imm, iss_ex_aluop,
                     iss_ex_funct3, iss_ex_regdest, iss_ex_writereg,
                     iss_ex_readmem, iss_ex_writemem});
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(logic [6:0] opc, logic [2:0] f3,
        logic [6:0] f7, logic [2:0] aop, logic sel, logic [31:0] imm,
        logic [4:0] rd, logic wr, logic rm, logic wm, logic [4:0] ra,
        logic [4:0] rb);
        instr_t x;
        x.opc = opc; x.f3 = f3; x.f7 = f7; x.aop = aop; x.sel = sel;
        x.imm = imm; x.rd = rd; x.wr = wr; x.rm = rm; x.wm = wm;
        x.ra = ra; x.rb = rb;
        return x;
    endfunction

    // 0 = ALU, 1 = MUL, 2 = MEM
    function automatic int fu_of(instr_t x);
        if (x.opc == 7'b0110011 && x.f7 == 7'b0000001) return 1;
        if (x.opc == 7'b0000011 || x.opc == 7'b0100011) return 2;
        return 0;
    endfunction

    function automatic logic rdy(int fu);
        return (fu == 1) ? mul_iss_ready : (fu == 2) ? mem_iss_ready
                                                     : alu_iss_ready;
    endfunction

    function automatic logic wb_hit(logic [4:0] r);
        return wb_iss_writereg && (wb_iss_addr == r);
    endfunction

    function automatic logic busy(logic [4:0] r);
        return (r != 0) && m_pend[r] && !wb_hit(r);
    endfunction

    function automatic logic [31:0] opval(logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_hit(r)) return wb_iss_data;
        return rf[r];
    endfunction

    task automatic model_reset();
        m_held = 1'b0; m_ins = '0; m_pend = '0; m_v = '0; m_pay = '0;
        m_cnt = 0;
    endtask

    // One clock cycle: inputs are already driven (at negedge). Predict,
    // compare, advance the model after the edge, return at next negedge.
    task automatic step(input bit chk);
        int fu;
        logic disp, stl, cap;
        logic [127:0] pay;
        #1;
        fu   = fu_of(m_ins);
        disp = m_held && !ex_iss_flush && !busy(m_ins.ra) && !busy(m_ins.rb)
               && !(m_ins.wr && busy(m_ins.rd)) && rdy(fu);
        stl  = m_held && !disp;
        cap  = id_iss_valid && !stl && !ex_iss_flush;
        pay  = 128'({opval(m_ins.ra), m_ins.sel ? m_ins.imm : opval(m_ins.rb),
                     m_ins.imm, m_ins.aop, m_ins.f3, m_ins.rd, m_ins.wr,
                     m_ins.rm, m_ins.wm});
        if (chk) begin
            check("stall", 128'(iss_stall), 128'(stl));
            check("reg_addr", 128'({iss_reg_addra, iss_reg_addrb}),
                  128'({m_ins.ra, m_ins.rb}));
            check("valids", 128'({iss_alu_valid, iss_mul_valid, iss_mem_valid}),
                  128'(m_v));
            check("payload", dut_pay(), m_pay);
            check("stall_cycles", 128'(iss_stall_cycles), 128'(m_cnt));
        end
        @(posedge clock);
        #1;
        if (disp) begin
            m_v   = 3'b100 >> fu;
            m_pay = pay;
        end else begin
            m_v = 3'b000;
        end
        if (wb_iss_writereg) begin
            m_pend[wb_iss_addr] = 1'b0;
            if (wb_iss_addr != 0) rf[wb_iss_addr] = wb_iss_data;
        end
        if (disp && m_ins.wr && m_ins.rd != 0) m_pend[m_ins.rd] = 1'b1;
        if (stl && !ex_iss_flush && m_cnt < 65535) m_cnt++;
        if (ex_iss_flush)  m_held = 1'b0;
        else if (cap)      begin m_held = 1'b1; m_ins = in_i; end
        else if (disp)     m_held = 1'b0;
        @(negedge clock);
    endtask

    // Asynchronous reset asserted mid-phase; outputs must clear without
    // any clock edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_stall", 128'(iss_stall), 128'(0));
        check("rst_valids", 128'({iss_alu_valid, iss_mul_valid, iss_mem_valid}),
              128'(0));
        check("rst_payload", dut_pay(), 128'(0));
        check("rst_stall_cycles", 128'(iss_stall_cycles), 128'(0));
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    function automatic instr_t rand_instr();
        logic [6:0] ops [5];
        logic [6:0] f7s [3];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011;
        f7s[0] = 7'b0000000; f7s[1] = 7'b0000001; f7s[2] = 7'b0100000;
        return mk(ops[$urandom_range(4)], 3'($urandom), f7s[$urandom_range(2)],
                  3'($urandom), 1'($urandom), $urandom, 5'($urandom_range(7)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  5'($urandom_range(7)), 5'($urandom_range(7)));
    endfunction

    task automatic idle_inputs();
        id_iss_valid = 1'b0; in_i = '0;
        wb_iss_writereg = 1'b0; wb_iss_addr = '0; wb_iss_data = '0;
        alu_iss_ready = 1'b1; mul_iss_ready = 1'b1; mem_iss_ready = 1'b1;
        ex_iss_flush = 1'b0;
    endtask

    initial begin
        rf[0] = 32'hDEADBEEF;   // must never leak through as operand x0
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        idle_inputs();
        model_reset();
        do_reset();

        // RAW stall on x5, released by a same-cycle writeback
        in_i = mk(7'b0010011, 0, 0, 0, 1, 32'd7, 5, 1, 0, 0, 1, 0);
        id_iss_valid = 1'b1; step(1);
        in_i = mk(7'b0110011, 0, 0, 0, 0, 0, 6, 1, 0, 0, 5, 1);
        step(1);
        check("addi_alu_valid", 128'(iss_alu_valid), 128'(1));
        id_iss_valid = 1'b0;
        step(1); step(1); step(1);
        check("add_raw_stall", 128'(iss_stall), 128'(1));
        wb_iss_writereg = 1'b1; wb_iss_addr = 5'd5; wb_iss_data = 32'h1234;
        step(1);
        wb_iss_writereg = 1'b0;
        check("add_bypass_valid", 128'(iss_alu_valid), 128'(1));
        check("add_bypass_opa", 128'(iss_ex_opa), 128'(32'h1234));
        step(1);

        // MUL waits for its unit for three cycles
        mul_iss_ready = 1'b0;
        in_i = mk(7'b0110011, 0, 7'b0000001, 0, 0, 0, 7, 1, 0, 0, 2, 3);
        id_iss_valid = 1'b1; step(1);
        id_iss_valid = 1'b0;
        step(1); step(1); step(1);
        mul_iss_ready = 1'b1; step(1);
        check("mul_valid", 128'(iss_mul_valid), 128'(1));
        step(1);
        check("mul_valid_once", 128'(iss_mul_valid), 128'(0));

        // Flush a held load
        in_i = mk(7'b0000011, 3'b010, 0, 0, 1, 32'd16, 8, 1, 1, 0, 2, 0);
        id_iss_valid = 1'b1; step(1);
        id_iss_valid = 1'b0; ex_iss_flush = 1'b1; step(1);
        ex_iss_flush = 1'b0;
        check("flush_no_mem", 128'(iss_mem_valid), 128'(0));
        check("flush_empty", 128'(iss_stall), 128'(0));
        step(1);

        // Write to x0, then a reader of x0 must not stall and sees zero
        in_i = mk(7'b0010011, 0, 0, 0, 1, 32'd5, 0, 1, 0, 0, 1, 0);
        id_iss_valid = 1'b1; step(1);
        in_i = mk(7'b0110011, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        step(1);
        id_iss_valid = 1'b0; step(1);
        check("x0_reader_valid", 128'(iss_alu_valid), 128'(1));
        check("x0_opa", 128'(iss_ex_opa), 128'(0));
        check("x0_opb", 128'(iss_ex_opb), 128'(0));

        // Long stall drives the counter into saturation
        mul_iss_ready = 1'b0;
        in_i = mk(7'b0110011, 0, 7'b0000001, 0, 0, 0, 10, 1, 0, 0, 2, 3);
        id_iss_valid = 1'b1; step(1);
        id_iss_valid = 1'b0;
        for (int i = 0; i < 70000; i++) step(0);
        check("stall_cycles_sat", 128'(iss_stall_cycles), 128'(16'hFFFF));
        step(1);
        mul_iss_ready = 1'b1; step(1); step(1);

        // Reset mid-operation drops the held entry and pending x11
        in_i = mk(7'b0010011, 0, 0, 0, 1, 32'd3, 11, 1, 0, 0, 1, 0);
        id_iss_valid = 1'b1; step(1);
        in_i = mk(7'b0110011, 0, 0, 0, 0, 0, 12, 1, 0, 0, 11, 0);
        step(1);
        id_iss_valid = 1'b0; step(1);
        do_reset();
        check("post_rst_addr", 128'({iss_reg_addra, iss_reg_addrb}), 128'(0));
        in_i = mk(7'b0110011, 0, 0, 0, 0, 0, 12, 1, 0, 0, 11, 0);
        id_iss_valid = 1'b1; step(1);
        id_iss_valid = 1'b0; step(1);
        check("post_rst_no_raw", 128'(iss_alu_valid), 128'(1));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                idle_inputs();
                do_reset();
            end
            id_iss_valid    = ($urandom_range(9) < 7);
            in_i            = rand_instr();
            alu_iss_ready   = ($urandom_range(3) != 0);
            mul_iss_ready   = ($urandom_range(3) != 0);
            mem_iss_ready   = ($urandom_range(3) != 0);
            wb_iss_writereg = ($urandom_range(9) < 3);
            wb_iss_addr     = 5'($urandom_range(7));
            wb_iss_data     = $urandom;
            ex_iss_flush    = ($urandom_range(29) == 0);
            step(1);
        end
        idle_inputs();
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
